// File: rtl/ber_window_acc.sv
// ber_window_acc: windowed BER accumulator with per-window result latch and sticky loss-of-sync detection.
module ber_window_acc #(
  parameter int EBW     = 16,
  parameter int BBW     = 24,
  parameter int LOSS_TH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           stop_i,
  input  logic           bit_vld_i,
  input  logic           bit_err_i,
  input  logic           win_end_i,
  output logic [EBW-1:0] err_cnt_o,
  output logic [BBW-1:0] bit_cnt_o,
  output logic           err_sat_o,
  output logic           res_vld_o,
  output logic           los_o,
  output logic           busy_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [EBW-1:0] err_acc_q, err_acc_d, err_fin, err_cnt_q;
  logic [BBW-1:0] bit_acc_q, bit_acc_d, bit_fin, bit_cnt_q;
  logic [15:0] run_q, run_d, run_inc;
  logic sat_q, sat_d, sat_fin, err_sat_q, res_vld_q, los_q, los_d;
  logic active, inc_b, inc_e, latch;
  always_comb begin
    state_d = stop_i ? IDLE : start_i ? RUN : state_q;
    active  = (state_q == RUN) && !start_i;
    inc_b   = active && bit_vld_i;
    inc_e   = inc_b && bit_err_i;
    latch   = active && win_end_i;
    bit_fin = bit_acc_q + BBW'(inc_b && !(&bit_acc_q));
    err_fin = err_acc_q + EBW'(inc_e && !(&err_acc_q));
    sat_fin = sat_q | (inc_b & (&bit_acc_q)) | (inc_e & (&err_acc_q));
    bit_acc_d = (start_i || latch) ? '0 : bit_fin;
    err_acc_d = (start_i || latch) ? '0 : err_fin;
    sat_d     = (start_i || latch) ? 1'b0 : sat_fin;
    // Run counter saturates so a very long error burst cannot wrap back below the threshold.
    run_inc = run_q + 16'(run_q != 16'hffff);
    run_d   = start_i ? '0 : !inc_b ? run_q : bit_err_i ? run_inc : '0;
    los_d   = start_i ? 1'b0 : los_q | (inc_e && run_inc == 16'(LOSS_TH));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      err_acc_q <= '0;
      bit_acc_q <= '0;
      sat_q     <= 1'b0;
      run_q     <= '0;
      los_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
      err_sat_q <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_acc_q <= err_acc_d;
      bit_acc_q <= bit_acc_d;
      sat_q     <= sat_d;
      run_q     <= run_d;
      los_q     <= los_d;
      res_vld_q <= latch;
      if (latch) begin
        err_cnt_q <= err_fin;
        bit_cnt_q <= bit_fin;
        err_sat_q <= sat_fin;
      end
    end
  end
  assign err_cnt_o = err_cnt_q;
  assign bit_cnt_o = bit_cnt_q;
  assign err_sat_o = err_sat_q;
  assign res_vld_o = res_vld_q;
  assign los_o     = los_q;
  assign busy_o    = (state_q == RUN);
endmodule

// File: tb/tb_ber_window_acc.sv
// tb_ber_window_acc: drives a default and a narrow-width ber_window_acc with directed and random traffic against a count-based model.
module tb_ber_window_acc;
  logic clk = 1'b0;
  logic rst, start, stop, vld, err, wend;
  logic [15:0] err_a;
  logic [23:0] bit_a;
  logic [3:0] err_b;
  logic [7:0] bit_b;
  logic sat_a, rv_a, los_a, busy_a, sat_b, rv_b, los_b, busy_b;
  int n_chk = 0, n_fail = 0;
  int nb[2], ne[2], rl[2], ecnt[2], bcnt[2];
  bit esat[2], rv[2], los[2], mrun;
  int mx_e[2] = '{65535, 15};
  int mx_b[2] = '{16777215, 255};
  int th[2] = '{32, 5};

  always #5 clk = ~clk;

  ber_window_acc dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .bit_vld_i(vld),
    .bit_err_i(err), .win_end_i(wend), .err_cnt_o(err_a), .bit_cnt_o(bit_a),
    .err_sat_o(sat_a), .res_vld_o(rv_a), .los_o(los_a), .busy_o(busy_a)
  );

  ber_window_acc #(.EBW(4), .BBW(8), .LOSS_TH(5)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .bit_vld_i(vld),
    .bit_err_i(err), .win_end_i(wend), .err_cnt_o(err_b), .bit_cnt_o(bit_b),
    .err_sat_o(sat_b), .res_vld_o(rv_b), .los_o(los_b), .busy_o(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Result = window totals clipped at the accumulator maximum; saturated when a total exceeded it.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      rv[k] = 1'b0;
      if (rst) begin
        nb[k] = 0; ne[k] = 0; rl[k] = 0; los[k] = 1'b0;
        ecnt[k] = 0; bcnt[k] = 0; esat[k] = 1'b0;
      end else begin
        if (mrun && !start) begin
          if (vld) begin
            nb[k]++;
            if (err) begin
              ne[k]++;
              rl[k]++;
              if (rl[k] == th[k]) los[k] = 1'b1;
            end else rl[k] = 0;
          end
          if (wend) begin
            ecnt[k] = ne[k] > mx_e[k] ? mx_e[k] : ne[k];
            bcnt[k] = nb[k] > mx_b[k] ? mx_b[k] : nb[k];
            esat[k] = (ne[k] > mx_e[k]) || (nb[k] > mx_b[k]);
            rv[k] = 1'b1;
            nb[k] = 0; ne[k] = 0;
          end
        end
        if (start) begin
          nb[k] = 0; ne[k] = 0; rl[k] = 0; los[k] = 1'b0;
        end
      end
    end
    mrun = rst ? 1'b0 : stop ? 1'b0 : start ? 1'b1 : mrun;
  endtask

  task automatic tick(input bit s, input bit p, input bit v, input bit e, input bit w, input bit r);
    start = s; stop = p; vld = v; err = e; wend = w; rst = r;
    @(posedge clk);
    model_step();
    #1;
    chk("a.err", 32'(err_a), ecnt[0]);
    chk("a.bit", 32'(bit_a), bcnt[0]);
    chk("a.sat", 32'(sat_a), 32'(esat[0]));
    chk("a.rv", 32'(rv_a), 32'(rv[0]));
    chk("a.los", 32'(los_a), 32'(los[0]));
    chk("a.busy", 32'(busy_a), 32'(mrun));
    chk("b.err", 32'(err_b), ecnt[1]);
    chk("b.bit", 32'(bit_b), bcnt[1]);
    chk("b.sat", 32'(sat_b), 32'(esat[1]));
    chk("b.rv", 32'(rv_b), 32'(rv[1]));
    chk("b.los", 32'(los_b), 32'(los[1]));
    chk("b.busy", 32'(busy_b), 32'(mrun));
  endtask

  initial begin
    mrun = 1'b0;
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 1, 1, 1, 1);
    chk("rst.bit", 32'(bit_a), 0);
    chk("rst.busy", 32'(busy_a), 0);
    tick(0, 0, 1, 1, 1, 0);
    chk("idle.rv", 32'(rv_a), 0);
    // single 100-bit window, errors on bits 10/20/30
    tick(1, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 100; i++) tick(0, 0, 1, i % 10 == 0 && i <= 30, i == 100, 0);
    chk("t1.bit", 32'(bit_a), 100);
    chk("t1.err", 32'(err_a), 3);
    chk("t1.sat", 32'(sat_a), 0);
    chk("t1.rv", 32'(rv_a), 1);
    tick(0, 0, 0, 0, 0, 0);
    chk("t1.rv_off", 32'(rv_a), 0);
    // back-to-back 8-bit windows
    for (int i = 1; i <= 16; i++) begin
      tick(0, 0, 1, i == 3 || i == 5, i == 8 || i == 16, 0);
      if (i == 8) chk("t2.err0", 32'(err_a), 2);
      if (i == 16) begin
        chk("t2.err1", 32'(err_a), 0);
        chk("t2.rv1", 32'(rv_a), 1);
      end
    end
    // error saturation on the narrow instance
    for (int i = 1; i <= 20; i++) tick(0, 0, 1, 1, i == 20, 0);
    chk("t3.errb", 32'(err_b), 15);
    chk("t3.satb", 32'(sat_b), 1);
    chk("t3.erra", 32'(err_a), 20);
    for (int i = 1; i <= 5; i++) tick(0, 0, 1, 0, i == 5, 0);
    chk("t3.satb_clr", 32'(sat_b), 0);
    // loss of sync threshold
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 63; i++) tick(0, 0, 1, i != 31, 0, 0);
    chk("t4.los0", 32'(los_a), 0);
    tick(0, 0, 1, 1, 0, 0);
    chk("t4.los1", 32'(los_a), 1);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, 0, i == 5, 0);
    chk("t4.sticky", 32'(los_a), 1);
    tick(1, 0, 0, 0, 0, 0);
    chk("t4.clr", 32'(los_a), 0);
    // simultaneous events
    for (int i = 0; i < 6; i++) tick(0, 0, 1, i == 2, 0, 0);
    tick(0, 1, 1, 0, 1, 0);
    chk("t5.stopw.rv", 32'(rv_a), 1);
    chk("t5.stopw.bit", 32'(bit_a), 7);
    chk("t5.stopw.busy", 32'(busy_a), 0);
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 0, 0);
    tick(1, 0, 1, 0, 1, 0);
    chk("t5.startw.rv", 32'(rv_a), 0);
    chk("t5.startw.busy", 32'(busy_a), 1);
    tick(1, 1, 0, 0, 0, 0);
    chk("t5.startstop", 32'(busy_a), 0);
    // reset mid-window
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) tick(0, 0, 1, i % 7 == 0, 0, 0);
    tick(0, 0, 1, 1, 0, 1);
    chk("t6.busy", 32'(busy_a), 0);
    chk("t6.bit", 32'(bit_a), 0);
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) tick(0, 0, 1, 0, i == 10, 0);
    chk("t6.fresh", 32'(bit_a), 10);
    // bit accumulator saturation on the narrow instance
    for (int i = 1; i <= 300; i++) tick(0, 0, 1, i % 50 == 0, i == 300, 0);
    chk("t7.bitb", 32'(bit_b), 255);
    chk("t7.satb", 32'(sat_b), 1);
    // random traffic with phases of dense and sparse errors
    for (int i = 0; i < 4000; i++) begin
      int ep;
      ep = (i / 500) % 2 ? 95 : 20;
      tick($urandom_range(99) < 2, $urandom_range(99) < 2, $urandom_range(99) < 80,
           $urandom_range(99) < ep, $urandom_range(99) < 3, $urandom_range(999) < 3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
